// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Word-organised data RAM plus a small MMIO window (LEDs, switches,
//            cycle counter, status), answering the data cache's memory port.
// Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
   parameter int          DEPTH_LOG2 = 14,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FC00,
   parameter int          SW_WIDTH   = 16,
   parameter int          LED_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          MemAddr,
   input  logic [31:0]          MemWriteData,
   input  logic                 MemWe,
   output logic [31:0]          MemData,
   input  logic [SW_WIDTH-1:0]  Switches,
   output logic [LED_WIDTH-1:0] Leds,
   output logic                 AccessErr
);

   localparam int          DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;

   localparam logic [5:0] OFF_LED    = 6'd0;
   localparam logic [5:0] OFF_SW     = 6'd1;
   localparam logic [5:0] OFF_CYCLES = 6'd2;
   localparam logic [5:0] OFF_STATUS = 6'd3;

   typedef enum logic [1:0] {
      SRC_ZERO = 2'd0,
      SRC_RAM  = 2'd1,
      SRC_MMIO = 2'd2
   } rd_src_e;

   // Address decode and next-state signals
   logic                  is_ram;
   logic                  is_mmio;
   logic                  is_illegal;
   logic [5:0]            mmio_off;
   logic [DEPTH_LOG2-1:0] ram_idx;
   logic                  ram_we;
   logic [31:0]           mmio_rdata;

   rd_src_e               rd_src_d,    rd_src_q;
   logic [31:0]           mmio_rd_d,   mmio_rd_q;
   logic [LED_WIDTH-1:0]  leds_d,      leds_q;
   logic [31:0]           cycles_d,    cycles_q;
   logic                  access_err_d, access_err_q;
   logic [SW_WIDTH-1:0]   sw_meta_q,   sw_sync_q;

   logic [31:0]           ram_mem [DEPTH];
   logic [31:0]           ram_rd_q;

   always_comb begin
      is_ram     = ({1'b0, MemAddr} < RAM_BYTES);
      is_mmio    = (MemAddr[31:8] == MMIO_BASE[31:8]);
      is_illegal = !is_ram && !is_mmio;
      mmio_off   = MemAddr[7:2];
      ram_idx    = MemAddr[DEPTH_LOG2+1:2];
      ram_we     = MemWe && is_ram;
   end

   always_comb begin
      mmio_rdata = 32'd0;
      unique case (mmio_off)
         OFF_LED:    mmio_rdata[LED_WIDTH-1:0] = leds_q;
         OFF_SW:     mmio_rdata[SW_WIDTH-1:0]  = sw_sync_q;
         OFF_CYCLES: mmio_rdata                = cycles_q;
         OFF_STATUS: mmio_rdata[0]             = access_err_q;
         default:    mmio_rdata                = 32'd0;
      endcase
   end

   always_comb begin
      leds_d       = leds_q;
      cycles_d     = cycles_q + 32'd1;
      access_err_d = access_err_q;
      rd_src_d     = SRC_ZERO;
      mmio_rd_d    = 32'd0;

      if (is_ram) begin
         rd_src_d = SRC_RAM;
      end else if (is_mmio) begin
         rd_src_d  = SRC_MMIO;
         mmio_rd_d = mmio_rdata;
      end

      if (MemWe && is_mmio) begin
         if (mmio_off == OFF_LED) leds_d = MemWriteData[LED_WIDTH-1:0];
         // Clear beats the free-running increment in the same cycle.
         if (mmio_off == OFF_CYCLES) cycles_d = 32'd0;
         if (mmio_off == OFF_STATUS && MemWriteData[0]) access_err_d = 1'b0;
      end

      if (is_illegal) access_err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_src_q     <= SRC_ZERO;
         mmio_rd_q    <= 32'd0;
         leds_q       <= '0;
         cycles_q     <= 32'd0;
         access_err_q <= 1'b0;
         sw_meta_q    <= '0;
         sw_sync_q    <= '0;
      end else begin
         rd_src_q     <= rd_src_d;
         mmio_rd_q    <= mmio_rd_d;
         leds_q       <= leds_d;
         cycles_q     <= cycles_d;
         access_err_q <= access_err_d;
         sw_meta_q    <= Switches;
         sw_sync_q    <= sw_meta_q;
      end
   end

   // Contents are never cleared; reset only blocks writes, including one landing on the asserting edge.
   always_ff @(posedge clk or posedge rst) begin
      if (!rst) begin
         if (ram_we) ram_mem[ram_idx] <= MemWriteData;
         ram_rd_q <= ram_mem[ram_idx];
      end
   end

   always_comb begin
      MemData = 32'd0;
      unique case (rd_src_q)
         SRC_RAM:  MemData = ram_rd_q;
         SRC_MMIO: MemData = mmio_rd_q;
         default:  MemData = 32'd0;
      endcase
   end

   assign Leds      = leds_q;
   assign AccessErr = access_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed vector table plus hand sequences for dmem_responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

   localparam logic [31:0] B = 32'hFFFF_FC00;

   logic        clk;
   logic        rst;
   logic [31:0] MemAddr;
   logic [31:0] MemWriteData;
   logic        MemWe;
   logic [31:0] MemData;
   logic [15:0] Switches;
   logic [15:0] Leds;
   logic        AccessErr;

   int total;
   int passed;

   dmem_responder dut (
      .clk          (clk),
      .rst          (rst),
      .MemAddr      (MemAddr),
      .MemWriteData (MemWriteData),
      .MemWe        (MemWe),
      .MemData      (MemData),
      .Switches     (Switches),
      .Leds         (Leds),
      .AccessErr    (AccessErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic [15:0] exp_leds;
   } vec_t;

   vec_t vecs [23];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      MemWe        = we;
      MemAddr      = addr;
      MemWriteData = wdata;
   endtask

   initial begin
      bit seen;
      total  = 0;
      passed = 0;

      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 16'h0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 16'h0};
      vecs[2]  = '{1'b1, 32'h0000_0020, 32'hAAAA_AAAA, 1'b0, 32'h0,         1'b0, 16'h0};
      vecs[3]  = '{1'b1, 32'h0000_0020, 32'h1111_1111, 1'b1, 32'hAAAA_AAAA, 1'b0, 16'h0};
      vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'h1111_1111, 1'b0, 16'h0};
      vecs[5]  = '{1'b1, 32'h0000_0000, 32'h1,         1'b0, 32'h0,         1'b0, 16'h0};
      vecs[6]  = '{1'b1, 32'h0000_0004, 32'h2,         1'b0, 32'h0,         1'b0, 16'h0};
      vecs[7]  = '{1'b1, 32'h0000_0008, 32'h3,         1'b0, 32'h0,         1'b0, 16'h0};
      vecs[8]  = '{1'b1, 32'h0000_000C, 32'h4,         1'b0, 32'h0,         1'b0, 16'h0};
      vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1,         1'b0, 16'h0};
      vecs[10] = '{1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'h2,         1'b0, 16'h0};
      vecs[11] = '{1'b0, 32'h0000_0008, 32'h0,         1'b1, 32'h3,         1'b0, 16'h0};
      vecs[12] = '{1'b0, 32'h0000_000C, 32'h0,         1'b1, 32'h4,         1'b0, 16'h0};
      vecs[13] = '{1'b1, 32'h0000_FFFC, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0, 16'h0};
      vecs[14] = '{1'b0, 32'h0000_FFFC, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0, 16'h0};
      vecs[15] = '{1'b1, B + 32'h00,    32'h1234_5A5A, 1'b1, 32'h0,         1'b0, 16'h5A5A};
      vecs[16] = '{1'b0, B + 32'h00,    32'h0,         1'b1, 32'h0000_5A5A, 1'b0, 16'h5A5A};
      vecs[17] = '{1'b1, B + 32'h04,    32'hFFFF_FFFF, 1'b1, 32'h0,         1'b0, 16'h5A5A};
      vecs[18] = '{1'b0, B + 32'h04,    32'h0,         1'b1, 32'h0,         1'b0, 16'h5A5A};
      vecs[19] = '{1'b0, B + 32'h10,    32'h0,         1'b1, 32'h0,         1'b0, 16'h5A5A};
      vecs[20] = '{1'b1, B + 32'h40,    32'hFFFF_FFFF, 1'b1, 32'h0,         1'b0, 16'h5A5A};
      vecs[21] = '{1'b0, B + 32'h0C,    32'h0,         1'b1, 32'h0,         1'b0, 16'h5A5A};
      vecs[22] = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 16'h5A5A};

      rst      = 1'b1;
      Switches = 16'h0;
      drive(1'b0, 32'h0, 32'h0);
      step();
      step();
      check("reset MemData", MemData, 32'h0);
      check("reset Leds", {16'h0, Leds}, 32'h0);
      check("reset AccessErr", {31'h0, AccessErr}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 23; i++) begin
         drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
         step();
         if (vecs[i].chk) check($sformatf("vec%0d MemData", i), MemData, vecs[i].exp_rd);
         check($sformatf("vec%0d AccessErr", i), {31'h0, AccessErr}, {31'h0, vecs[i].exp_err});
         check($sformatf("vec%0d Leds", i), {16'h0, Leds}, {16'h0, vecs[i].exp_leds});
      end

      // Switch synchroniser: value must appear on a held SW read within 3 clocks
      Switches = 16'h00F0;
      drive(1'b0, B + 32'h04, 32'h0);
      seen = 1'b0;
      for (int i = 0; i < 3 && !seen; i++) begin
         step();
         if (MemData === 32'h0000_00F0) seen = 1'b1;
      end
      check("switch latency", MemData, 32'h0000_00F0);

      // Illegal write: flag set, data zero, RAM word 0 untouched
      drive(1'b1, 32'h8000_0000, 32'h0BAD_0BAD);
      step();
      check("illegal err", {31'h0, AccessErr}, 32'h1);
      check("illegal MemData", MemData, 32'h0);
      drive(1'b0, 32'h0000_0000, 32'h0);
      step();
      check("ram word0 intact", MemData, 32'h1);
      drive(1'b0, B + 32'h0C, 32'h0);
      step();
      check("status read", MemData, 32'h1);
      drive(1'b1, B + 32'h0C, 32'hFFFF_FFFE);
      step();
      check("status bit0=0 keeps err", {31'h0, AccessErr}, 32'h1);
      drive(1'b1, B + 32'h0C, 32'h1);
      step();
      check("status clear", {31'h0, AccessErr}, 32'h0);
      drive(1'b0, 32'h0001_0000, 32'h0);
      step();
      check("ram end+1 err", {31'h0, AccessErr}, 32'h1);
      check("ram end+1 MemData", MemData, 32'h0);
      drive(1'b1, B + 32'h0C, 32'h1);
      step();
      check("status clear 2", {31'h0, AccessErr}, 32'h0);

      // Cycle counter: clear, then read while held
      drive(1'b1, B + 32'h08, 32'h0000_FFFF);
      step();
      drive(1'b0, B + 32'h08, 32'h0);
      repeat (10) step();
      check("cycles after 10", MemData, 32'd9);
      step();
      check("cycles after 11", MemData, 32'd10);

      // Mid-cycle asynchronous reset with a write pending
      drive(1'b0, 32'h8000_0000, 32'h0);
      step();
      drive(1'b0, 32'h0000_0010, 32'h0);
      step();
      check("pre-reset MemData", MemData, 32'hDEAD_BEEF);
      check("pre-reset err", {31'h0, AccessErr}, 32'h1);
      #2;
      rst = 1'b1;
      drive(1'b1, 32'h0000_0000, 32'h5555_5555);
      #1;
      check("async rst MemData", MemData, 32'h0);
      check("async rst Leds", {16'h0, Leds}, 32'h0);
      check("async rst err", {31'h0, AccessErr}, 32'h0);
      step();
      rst = 1'b0;
      drive(1'b0, B + 32'h08, 32'h0);
      step();
      check("cycles after rst", MemData, 32'h0);
      drive(1'b0, 32'h0000_0000, 32'h0);
      step();
      check("ram kept over rst", MemData, 32'h1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
